alu_share_sequencer: RTL and testbench
======================================

# alu_share_sequencer

Sequencer and arbiter that shares one ALU between two requesters, such as the core datapath and a secondary address/compare unit. It accepts an operation (4-bit ALU control code plus two operands) from requester 0 or 1 with round-robin arbitration. It drives the operation into the external ALU, registers the result, and returns it on a single response channel tagged with the requester ID. It sits between the requesters and the ALU's control/operand inputs, replacing direct wiring of ALU control codes.

## Interface
- `WIDTH`, 32, operand and result width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU control code (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT).
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_op`  out  4  registered control code to the shared ALU.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the shared ALU.
- `alu_result`  in  WIDTH  combinational ALU result.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  WIDTH  registered result.
- `resp_id`  out  1  requester that issued the operation.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `reqN_valid` is high, the grant is chosen.
  - `reqN_ready` is high combinationally for the granted requester only, and only in IDLE.
  - On that edge: `alu_op`/`alu_a`/`alu_b` capture the granted request, `resp_id` captures the grant, `last_grant` updates, and the FSM goes to EXEC.
- **EXEC**
  - ALU inputs are stable from the registers.
  - `resp_data` captures `alu_result`; the FSM goes to RESP.
- **RESP**
  - `resp_valid` is high.
  - When `resp_ready` is high, the FSM goes to IDLE at the edge.
  - `resp_data`/`resp_id` are held stable while `resp_valid` && !`resp_ready`.
- **Round-robin**
  - If both requesters are valid, grant the one that is not `last_grant`.
  - If only one is valid, grant it.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- ALU input registers hold their last values in IDLE and RESP (no toggling).
- Opcodes 1001–1111 pass through unmodified. The ALU's default handling applies, and the response is still returned.
- `resp_data` is truncated/sized to WIDTH; there is no carry or overflow output.
- Requests arriving in EXEC/RESP wait with `ready` low; requesters must hold op/operands stable until `ready`.

## Timing
- Reset values:
  - state IDLE, `last_grant` 1.
  - `alu_op` 0000, `alu_a`/`alu_b` 0.
  - `resp_valid` 0, `resp_data` 0, `resp_id` 0.
  - `busy` 0, `req0_ready`/`req1_ready` 0.
- Latency:
  - Accept edge T, result captured at T+1.
  - `resp_valid` is high in the cycle after T+1.
  - If `resp_ready` is already high, the FSM is back in IDLE after edge T+2.
- Throughput: at most one operation per 3 cycles; there is no accept in the RESP→IDLE cycle.
- Reset asserted mid-operation: the in-flight operation is dropped and no response is issued. All state returns to reset values at that edge.
- `reset` overrides `reqN_valid` and `resp_ready` in the same cycle.

## Configuration
- `ALU_SEQ_FIXED_PRIO_EN`
  - **Defined:** fixed priority; requester 0 always wins when both are valid. `last_grant` is not implemented.
  - **Undefined (default):** round-robin as described under Operation.

## Test plan
- **Single op:** after reset, `req0` sends op 0000, a=5, b=7.
  - `req0_ready` is high in the first cycle.
  - `resp_valid` is high 2 cycles later with `resp_data`=12, `resp_id`=0.
- **Contention round-robin:** both valid continuously, `req0` SUB 10-3 and `req1` SLT 2<9.
  - Grants go 0, 1, 0, 1.
  - Responses are 7/id0 and 1/id1 alternating.
  - With `ALU_SEQ_FIXED_PRIO_EN` defined, all grants go to 0 while `req0_valid` is held.
- **Backpressure:** `resp_ready` is held low 5 cycles during RESP with SRA 0x80000000>>4.
  - `resp_data`=0xF8000000 is stable throughout.
  - Both `reqN_ready` stay low and `busy` stays 1.
- **Reset mid-op:** `reset` is pulsed in EXEC.
  - No `resp_valid` appears.
  - All outputs match reset values the next cycle.
  - The next request is accepted normally.
- **Illegal opcode:** `req1` op 1111, a=3, b=4.
  - Response is issued with id1; `resp_data` equals the ALU default (ADD, 7).
  - The FSM returns to IDLE.

Source files
------------

// File: rtl/alu_share_sequencer.sv
// rtl/alu_share_sequencer.sv - round-robin sequencer sharing one ALU between two requesters
// Optional macro ALU_SEQ_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module alu_share_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_id,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state;
   logic       grant;
   logic       accept;

`ifdef ALU_SEQ_FIXED_PRIO_EN
   always_comb begin
      grant = ~req0_valid;
   end
`else
   logic last_grant;

   // On contention the requester not served last time wins.
   always_comb begin
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else
         grant = ~req0_valid;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= grant;
   end
`endif

   // Reset suppresses the handshake so no request is lost during the reset cycle.
   assign accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         alu_op    <= 4'b0000;
         alu_a     <= '0;
         alu_b     <= '0;
         resp_data <= '0;
         resp_id   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_op  <= grant ? req1_op : req0_op;
                  alu_a   <= grant ? req1_a  : req0_a;
                  alu_b   <= grant ? req1_b  : req0_b;
                  resp_id <= grant;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               resp_data <= alu_result;
               state     <= RESP;
            end
            RESP: begin
               if (resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// tb/tb_alu_share_sequencer.sv - directed self-checking bench for alu_share_sequencer
// Honours ALU_SEQ_FIXED_PRIO_EN for the contention expectations.
module tb_alu_share_sequencer;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [3:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic             resp_valid, resp_ready, resp_id, busy;
   logic [WIDTH-1:0] resp_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_share_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
   );

   // External ALU; unknown codes fall back to ADD
   always_comb begin
      case (alu_op)
         4'b0001: alu_result = alu_a - alu_b;
         4'b0010: alu_result = alu_a & alu_b;
         4'b0011: alu_result = alu_a | alu_b;
         4'b0100: alu_result = alu_a ^ alu_b;
         4'b0101: alu_result = alu_a << alu_b[4:0];
         4'b0110: alu_result = alu_a >> alu_b[4:0];
         4'b0111: alu_result = $signed(alu_a) >>> alu_b[4:0];
         4'b1000: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = alu_a + alu_b;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},       32'(busy),       32'd0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_data"},  resp_data,       32'd0);
      chk({tag, "_resp_id"},    32'(resp_id),    32'd0);
      chk({tag, "_alu_op"},     32'(alu_op),     32'd0);
      chk({tag, "_alu_a"},      alu_a,           32'd0);
      chk({tag, "_alu_b"},      alu_b,           32'd0);
   endtask

   initial begin
      logic exp_g;
      reset = 1'b1; resp_ready = 1'b1;
      req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
      tick(); tick();
      chk("rst_rdy0", 32'(req0_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk_reset_vals("rst");

      // Single ADD 5+7 from requester 0
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd5; req0_b = 32'd7;
      #1;
      chk("single_rdy0", 32'(req0_ready), 32'd1);
      chk("single_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("single_exec_busy",  32'(busy),       32'd1);
      chk("single_exec_valid", 32'(resp_valid), 32'd0);
      chk("single_alu_a",      alu_a,           32'd5);
      tick();
      chk("single_valid", 32'(resp_valid), 32'd1);
      chk("single_data",  resp_data,       32'd12);
      chk("single_id",    32'(resp_id),    32'd0);
      tick();
      chk("single_idle_busy",  32'(busy),       32'd0);
      chk("single_idle_valid", 32'(resp_valid), 32'd0);

      // Contention from a fresh reset so requester 0 wins first
      reset = 1'b1; tick(); reset = 1'b0;
      req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd10; req0_b = 32'd3;
      req1_valid = 1'b1; req1_op = 4'b1000; req1_a = 32'd2;  req1_b = 32'd9;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_SEQ_FIXED_PRIO_EN
         exp_g = 1'b0;
`else
         exp_g = 1'(i % 2);
`endif
         #1;
         chk($sformatf("rr%0d_rdy0", i), 32'(req0_ready), 32'(!exp_g));
         chk($sformatf("rr%0d_rdy1", i), 32'(req1_ready), 32'(exp_g));
         tick(); tick();
         chk($sformatf("rr%0d_valid", i), 32'(resp_valid), 32'd1);
         chk($sformatf("rr%0d_id", i),    32'(resp_id),    32'(exp_g));
         chk($sformatf("rr%0d_data", i),  resp_data,       exp_g ? 32'd1 : 32'd7);
         tick();
      end

      // Backpressure: SRA 0x80000000 >>> 4 held in RESP for 5 cycles
      req0_op = 4'b0111; req0_a = 32'h8000_0000; req0_b = 32'd4;
      req1_op = 4'b0000; req1_a = 32'd1; req1_b = 32'd1;
      resp_ready = 1'b0;
      #1;
      chk("bp_rdy0", 32'(req0_ready), 32'd1);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_valid", i), 32'(resp_valid), 32'd1);
         chk($sformatf("bp%0d_data", i),  resp_data,       32'hF800_0000);
         chk($sformatf("bp%0d_id", i),    32'(resp_id),    32'd0);
         chk($sformatf("bp%0d_rdy0", i),  32'(req0_ready), 32'd0);
         chk($sformatf("bp%0d_rdy1", i),  32'(req1_ready), 32'd0);
         chk($sformatf("bp%0d_busy", i),  32'(busy),       32'd1);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
      tick();
      chk("bp_done_busy", 32'(busy), 32'd0);

      // Reset pulsed while the operation is in EXEC
      req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
      tick();
      req0_valid = 1'b0;
      chk("mid_in_exec", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_vals("mid");
      tick();
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
      req0_valid = 1'b1; req0_op = 4'b0100; req0_a = 32'hF0; req0_b = 32'hFF;
      #1;
      chk("post_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      chk("post_valid", 32'(resp_valid), 32'd1);
      chk("post_data",  resp_data,       32'h0F);
      tick();

      // Illegal opcode passes through; ALU falls back to ADD
      req1_valid = 1'b1; req1_op = 4'b1111; req1_a = 32'd3; req1_b = 32'd4;
      #1;
      chk("ill_rdy1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk("ill_alu_op", 32'(alu_op), 32'hF);
      tick();
      chk("ill_valid", 32'(resp_valid), 32'd1);
      chk("ill_id",    32'(resp_id),    32'd1);
      chk("ill_data",  resp_data,       32'd7);
      tick();
      chk("ill_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
